// File: rtl/watch_input_sequencer.sv
// Button front end for a watch: synchronize, debounce, and sequence mode/up/down into edit commands.
// Optional auto-repeat of up/down is enabled by defining WATCH_AUTOREPEAT_EN.
module watch_input_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_RATE     = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_raw,
    input  logic       up_raw,
    input  logic       down_raw,
    output logic       mode_pulse,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [1:0] edit_state,
    output logic       timeout_pulse
);

    localparam int unsigned NB = 3;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        DISPLAY   = 2'd0,
        SET_HOUR  = 2'd1,
        SET_MIN   = 2'd2,
        SET_ALARM = 2'd3
    } state_t;

    // Bit 0 = mode, bit 1 = up, bit 2 = down.
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_prev;
    logic [NB-1:0] press_c;

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          mode_d;
    logic          up_d;
    logic          down_d;
    logic          timeout_d;
    logic          in_edit_c;
    logic          both_c;
    logic [1:0]    fire_c;

    assign raw = {down_raw, up_raw, mode_raw};

    // Two-flop synchronizer plus edge history of the debounced levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb_prev <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
        end
    end

    // Per-input debouncer: level flips after DEBOUNCE_CYCLES consecutive differing samples.
    for (genvar g = 0; g < NB; g++) begin : g_deb
        logic [DW-1:0] cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                deb[g] <= 1'b0;
            end else if (sync2[g] == deb[g]) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                deb[g] <= sync2[g];
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

    assign press_c   = deb & ~deb_prev;
    assign in_edit_c = (state_q != DISPLAY);
    assign both_c    = deb[1] & deb[2];

`ifdef WATCH_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [1:0] rep_c;

    // Repeat timers for up (g=0) and down (g=1); armed only by an accepted initial press.
    for (genvar g = 0; g < 2; g++) begin : g_rpt
        logic [RW-1:0] cnt;
        logic          act;
        logic          first;
        logic          held;

        assign held     = deb[g+1] & ~both_c & in_edit_c & ~mode_pulse & ~press_c[0];
        assign rep_c[g] = act & held &
                          (cnt == (first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1)));

        always_ff @(posedge clk) begin
            if (reset || !held) begin
                act   <= 1'b0;
                first <= 1'b0;
                cnt   <= '0;
            end else if (press_c[g+1]) begin
                act   <= 1'b1;
                first <= 1'b1;
                cnt   <= '0;
            end else if (rep_c[g]) begin
                first <= 1'b0;
                cnt   <= '0;
            end else if (act) begin
                cnt <= cnt + RW'(1);
            end
        end
    end

    assign fire_c = press_c[2:1] | rep_c;
`else
    assign fire_c = press_c[2:1];
`endif

    // Edit-state register and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= DISPLAY;
            timer_q       <= '0;
            mode_pulse    <= 1'b0;
            up_pulse      <= 1'b0;
            down_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mode_pulse    <= mode_d;
            up_pulse      <= up_d;
            down_pulse    <= down_d;
            timeout_pulse <= timeout_d;
        end
    end

    // Next state, idle timer and pulse decisions; mode beats up/down, a press beats timeout.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        mode_d    = press_c[0];
        up_d      = in_edit_c & ~press_c[0] & ~both_c & fire_c[0];
        down_d    = in_edit_c & ~press_c[0] & ~both_c & fire_c[1];

        if (mode_pulse) begin
            case (state_q)
                DISPLAY:   state_d = SET_HOUR;
                SET_HOUR:  state_d = SET_MIN;
                SET_MIN:   state_d = SET_ALARM;
                default:   state_d = DISPLAY;
            endcase
        end

        if (!in_edit_c || mode_d || up_d || down_d || mode_pulse) begin
            timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timer_d   = '0;
            timeout_d = 1'b1;
            state_d   = DISPLAY;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    assign edit_state = state_q;

endmodule
